// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer: entry layout and pointer width.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package store_buffer_pkg;

    localparam int SB_DEPTH  = 4;
    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;
    localparam int PTR_W     = $clog2(SB_DEPTH);

    // One buffered store: a full word and its word-aligned byte address.
    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/sb_match.sv
// Address CAM over the store buffer: finds the youngest valid entry matching an address.
// Latency: combinational.
// Backpressure: none; pure lookup.
// Ports: entry_addr/valid = stored addresses and live bits, head = oldest slot,
//        addr = lookup address, hit/idx = match found and youngest matching slot.
module sb_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = SB_ADDR_W
) (
    input  logic [ADDR_W-1:0] entry_addr [DEPTH],
    input  logic [DEPTH-1:0]  valid,
    input  logic [PTR_W-1:0]  head,
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [PTR_W-1:0]  idx
);

    logic [DEPTH-1:0] eq;

    always_comb begin
        eq = '0;
        for (int k = 0; k < DEPTH; k++) begin
            eq[k] = valid[k] && (entry_addr[k] == addr);
        end
    end

    // Walk slots oldest-to-youngest starting at head; a later match overrides,
    // so the surviving index is the youngest store to that word.
    always_comb begin
        hit = 1'b0;
        idx = head;
        for (int k = 0; k < DEPTH; k++) begin
            if (eq[head + PTR_W'(k)]) begin
                hit = 1'b1;
                idx = head + PTR_W'(k);
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between MEM stage and data memory; loads take the port first.
// Latency: store reaches memory >=1 cycle after acceptance; loads are combinational.
// Backpressure: stall_o on full (without same-cycle pop), ungranted load, or active fence.
// Ports: clk_i/rst_n_i; cpu_* = MEM-stage request and load data; fence_i/fence_busy_o = drain;
//        mem_* = shared memory port (mem_gnt_i = port owned this cycle).
// Build option: define STORE_BUF_FWD_EN to forward buffered data to matching loads;
//        otherwise a matching load waits until those stores have drained.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cpu_wr_i,
    input  logic              cpu_rd_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_data_i,
    output logic [DATA_W-1:0] cpu_data_o,
    output logic              stall_o,
    input  logic              fence_i,
    output logic              fence_busy_o,
    input  logic              mem_gnt_i,
    output logic              mem_we_o,
    output logic              mem_re_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i
);

    entry_t             ents     [DEPTH];
    logic [ADDR_W-1:0]  ent_addr [DEPTH];
    logic [DEPTH-1:0]   valid;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [PTR_W:0]     count;

    logic               empty;
    logic               full;
    logic               fence_hold;
    logic               hit;
    logic [PTR_W-1:0]   hit_idx;
    logic               load_stall;
    logic               load_go;
    logic               store_stall;
    logic               push;
    logic               pop;
    logic [DATA_W-1:0]  load_data;

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            ent_addr[k] = ents[k].addr;
        end
    end

    sb_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_match (
        .entry_addr (ent_addr),
        .valid      (valid),
        .head       (head),
        .addr       (cpu_addr_i),
        .hit        (hit),
        .idx        (hit_idx)
    );

    assign empty      = (count == '0);
    assign full       = (count == (PTR_W+1)'(DEPTH));
    assign fence_hold = fence_i & ~empty;

`ifdef STORE_BUF_FWD_EN
    // A forwarded load is served from the buffer, so it does not need the grant.
    assign load_stall = cpu_rd_i & (fence_hold | (~hit & ~mem_gnt_i));
    assign load_data  = hit ? ents[hit_idx].data : mem_data_i;
`else
    // A load to a word still in the buffer waits; the port drains meanwhile.
    logic unused_ok;
    assign unused_ok  = &{1'b0, hit_idx};
    assign load_stall = cpu_rd_i & (fence_hold | hit | ~mem_gnt_i);
    assign load_data  = mem_data_i;
`endif

    assign load_go = cpu_rd_i & ~load_stall;

    // Any accepted load owns the cycle, so draining waits for a load-free cycle.
    assign pop         = ~load_go & mem_gnt_i & ~empty;
    assign store_stall = cpu_wr_i & (fence_hold | (full & ~pop));
    assign push        = cpu_wr_i & ~store_stall;

    assign stall_o      = load_stall | store_stall;
    assign fence_busy_o = fence_hold;
    assign mem_re_o     = cpu_rd_i & mem_gnt_i & ~stall_o;
    assign mem_we_o     = pop;
    assign mem_addr_o   = mem_re_o ? cpu_addr_i : (pop ? ents[head].addr : '0);
    assign mem_data_o   = pop ? ents[head].data : '0;
    assign cpu_data_o   = cpu_rd_i ? load_data : '0;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + PTR_W'(1);
            end
            // When full with a pop, tail equals head; this later write re-validates the slot.
            if (push) begin
                valid[tail] <= 1'b1;
                tail        <= tail + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload needs no reset: valid bits gate every use of it.
    always_ff @(posedge clk_i) begin
        if (push) begin
            ents[tail] <= '{addr: cpu_addr_i, data: cpu_data_i};
        end
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write FIFO between the MEM pipeline stage and the byte-addressed, word-wide data memory.
- Stores retire into the buffer in one cycle. The buffer drains them to memory whenever the memory port is granted and no load is using it.
- Loads have priority on the memory port and receive forwarded data from buffered stores to the same word.
- Lets the pipeline keep issuing while the memory port is shared with another requester (fetch/DMA arbiter).

Parameters:
- DEPTH, 4, number of buffered stores; power of two, at least 2.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; always one full word per entry.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- cpu_wr_i  input  1  store request from the MEM stage.
- cpu_rd_i  input  1  load request from the MEM stage; never asserted together with cpu_wr_i.
- cpu_addr_i  input  ADDR_W  load/store byte address; word-aligned (bits [1:0] = 0).
- cpu_data_i  input  DATA_W  store data.
- cpu_data_o  output  DATA_W  load data, combinational.
- stall_o  output  1  request not accepted this cycle; MEM stage holds.
- fence_i  input  1  drain request.
- fence_busy_o  output  1  high while fence_i=1 and the buffer is not empty.
- mem_gnt_i  input  1  memory port granted to this block this cycle.
- mem_we_o  output  1  memory write enable.
- mem_re_o  output  1  memory read enable.
- mem_addr_o  output  ADDR_W  memory address.
- mem_data_o  output  DATA_W  memory write data.
- mem_data_i  input  DATA_W  memory read data, combinational.

Behaviour:
- Storage: circular FIFO.
  - head/tail pointers are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits.
  - Each entry holds addr, data and a valid bit.
- Reset (asynchronous, any time, including mid-drain): pointers 0, count 0, all valid bits 0. Pending entries are discarded.
  - Resulting outputs: mem_we_o=0, mem_re_o=0, stall_o=0, fence_busy_o=0, mem_addr_o=0, mem_data_o=0, cpu_data_o=0.
- Load cycle: mem_re_o = cpu_rd_i & mem_gnt_i & ~stall_o; mem_addr_o = cpu_addr_i.
  - No drain happens in a load cycle.
  - A load with mem_gnt_i=0 stalls (stall_o=1).
- Forwarding: the youngest valid entry whose addr equals cpu_addr_i supplies cpu_data_o. Otherwise cpu_data_o = mem_data_i.
  - A forwarded load needs no grant and never stalls.
- Drain cycle: when there is no accepted load and mem_gnt_i=1 and count>0:
  - mem_we_o=1, mem_addr_o/mem_data_o = head entry.
  - At the rising edge the head entry is invalidated and head advances (pop).
- Enqueue: a store is accepted when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
  - The entry is written at tail; tail advances.
  - stall_o = cpu_wr_i & full & ~pop.
- A store and a pop in the same cycle leave count unchanged.
- A store entering an empty buffer is visible to mem_we_o no earlier than the next cycle; there is no same-cycle bypass.
- Stores always drain in program order. No merging or coalescing of entries.
- Fence: while fence_i=1 and count>0, fence_busy_o=1 and stall_o=1 for any cpu request. Drain continues.
- Latency: store to memory write takes at least 1 cycle after acceptance; loads are 0 cycles (combinational).

Optional Feature:
- Macro: STORE_BUF_FWD_EN.
- Defined: forwarding as described above.
- Undefined:
  - A load matching any valid entry asserts stall_o and is not issued.
  - The port is used for draining that cycle (if mem_gnt_i=1).
  - The load issues in the first cycle with no matching entry.
  - cpu_data_o is always mem_data_i.

Decomposition:
- Package store_buffer_pkg:
  - entry struct typedef {addr, data}.
  - Pointer-width constant PTR_W = $clog2(DEPTH).
- Sub-module sb_match: parallel address compare plus youngest-match priority select (age ordered relative to head). Returns hit and index.

Test Plan:
- Store 0x10←0xDEADBEEF with mem_gnt_i=1 → next cycle mem_we_o=1, mem_addr_o=0x10, mem_data_o=0xDEADBEEF; buffer then empty.
- mem_gnt_i=0, four stores (0x0,0x4,0x8,0xC) → all accepted; fifth store stall_o=1. Raise mem_gnt_i → fifth accepted in the same cycle 0x0 drains; count stays 4.
- mem_gnt_i=0, stores 0x20←1 then 0x20←2, load 0x20 → FWD_EN: cpu_data_o=2, stall_o=0. Without FWD_EN: stall_o=1 until both drained, then memory returns 2.
- Buffer holds 0x30, load 0x40 with mem_gnt_i=1 → mem_re_o=1, mem_addr_o=0x40, mem_we_o=0; 0x30 drains the following cycle.
- fence_i=1 with 3 entries, mem_gnt_i=1 → fence_busy_o high exactly 3 cycles, stores drain in order, cpu requests stalled.
- Reset asserted with 3 entries mid-drain → mem_we_o drops immediately; after release count=0 and a load to a previously buffered address reads memory.
